// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and digit-valid check for the serial BCD subtractor.
package bcd_pkg;
  localparam int DIGIT_W = 4;
  localparam int BCD_MAX = 9;

  typedef enum logic [1:0] {IDLE, SUB, DONE, FIX} state_e;

  function automatic logic digit_ok(input logic [DIGIT_W-1:0] dig);
    return dig <= DIGIT_W'(BCD_MAX);
  endfunction
endpackage

// File: rtl/bcd_digit_sub.sv
// Combinational single BCD digit subtract cell: d = a - b - bi with decimal wrap.
// Zero latency; inv flags an operand digit above 9 (arithmetic still applied, truncated).
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               bi,
  output logic [DIGIT_W-1:0] d,
  output logic               bo,
  output logic               inv
);
  logic [4:0] t;
  logic [4:0] t_fix;

  always_comb begin
    // 5-bit two's complement: operand range keeps t within -16..15
    t     = {1'b0, a} - {1'b0, b} - {4'b0, bi};
    t_fix = t + 5'd10;
    bo    = t[4];
    d     = bo ? t_fix[3:0] : t[3:0];
    inv   = !digit_ok(a) || !digit_ok(b);
  end
endmodule

// File: rtl/bcd_serial_subtractor.sv
// Packed-BCD D = A - B - Bin, one digit per clock LSD first; Done DIGITS+1 cycles after Start.
// Start accepted in IDLE/DONE only. Optional BCD_SIGN_MAG_EN adds a FIX pass giving magnitude + Neg.
module bcd_serial_subtractor
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                    Clock,
  input  logic                    Resetn,
  input  logic                    Start,
  input  logic [DIGIT_W*DIGITS-1:0] A,
  input  logic [DIGIT_W*DIGITS-1:0] B,
  input  logic                    Bin,
  output logic                    Busy,
  output logic                    Done,
  output logic [DIGIT_W*DIGITS-1:0] D,
  output logic                    Bout,
`ifdef BCD_SIGN_MAG_EN
  output logic                    Neg,
`endif
  output logic                    Err
);
  localparam int W  = DIGIT_W * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_e          state_q;
  logic [W-1:0]    a_q, b_q, acc_q, d_q;
  logic            bor_q, err_q, bout_q, errout_q;
  logic [IW-1:0]   idx_q;
  logic [W-1:0]    acc_d;
  logic            err_d, last;
  logic [DIGIT_W-1:0] cell_d;
  logic            cell_bo, cell_inv;
`ifdef BCD_SIGN_MAG_EN
  logic            neg_q;
  assign Neg = neg_q;
`endif

  bcd_digit_sub u_cell (
    .a   (a_q[DIGIT_W-1:0]),
    .b   (b_q[DIGIT_W-1:0]),
    .bi  (bor_q),
    .d   (cell_d),
    .bo  (cell_bo),
    .inv (cell_inv)
  );

  // Result digits enter at the top so digit 0 lands in [3:0] after DIGITS shifts
  assign acc_d = (acc_q >> DIGIT_W) | (W'(cell_d) << (W - DIGIT_W));
  assign err_d = err_q | cell_inv;
  assign last  = (idx_q == IW'(DIGITS - 1));

  assign Busy = (state_q == SUB) || (state_q == FIX);
  assign Done = (state_q == DONE);
  assign D    = d_q;
  assign Bout = bout_q;
  assign Err  = errout_q;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      d_q      <= '0;
      bor_q    <= 1'b0;
      err_q    <= 1'b0;
      bout_q   <= 1'b0;
      errout_q <= 1'b0;
      idx_q    <= '0;
`ifdef BCD_SIGN_MAG_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (Start) begin
            a_q     <= A;
            b_q     <= B;
            bor_q   <= Bin;
            acc_q   <= '0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            state_q <= SUB;
          end else begin
            state_q <= IDLE;
          end
        end
        SUB: begin
          a_q   <= a_q >> DIGIT_W;
          b_q   <= b_q >> DIGIT_W;
          bor_q <= cell_bo;
          acc_q <= acc_d;
          err_q <= err_d;
          idx_q <= idx_q + 1'b1;
          if (last) begin
            idx_q <= '0;
`ifdef BCD_SIGN_MAG_EN
            if (cell_bo) begin
              // Second pass 0 - D turns the ten's complement into a magnitude
              a_q     <= '0;
              b_q     <= acc_d;
              bor_q   <= 1'b0;
              state_q <= FIX;
            end else begin
              d_q      <= acc_d;
              bout_q   <= 1'b0;
              errout_q <= err_d;
              neg_q    <= 1'b0;
              state_q  <= DONE;
            end
`else
            d_q      <= acc_d;
            bout_q   <= cell_bo;
            errout_q <= err_d;
            state_q  <= DONE;
`endif
          end
        end
`ifdef BCD_SIGN_MAG_EN
        FIX: begin
          a_q   <= a_q >> DIGIT_W;
          b_q   <= b_q >> DIGIT_W;
          bor_q <= cell_bo;
          acc_q <= acc_d;
          idx_q <= idx_q + 1'b1;
          if (last) begin
            idx_q    <= '0;
            d_q      <= acc_d;
            bout_q   <= 1'b1;
            errout_q <= err_q;
            neg_q    <= 1'b1;
            state_q  <= DONE;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Randomized + directed bench for bcd_serial_subtractor against an integer-arithmetic reference.
module tb_bcd_serial_subtractor;
  logic        Clock, Resetn, Start, Bin;
  logic [15:0] A, B, D;
  logic        Busy, Done, Bout, Err;
`ifdef BCD_SIGN_MAG_EN
  logic        Neg;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_prev = 16'h0;

  bcd_serial_subtractor #(.DIGITS(4)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .Start  (Start),
    .A      (A),
    .B      (B),
    .Bin    (Bin),
    .Busy   (Busy),
    .Done   (Done),
    .D      (D),
    .Bout   (Bout),
`ifdef BCD_SIGN_MAG_EN
    .Neg    (Neg),
`endif
    .Err    (Err)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int bcd2int(input logic [15:0] x);
    int v = 0;
    for (int i = 3; i >= 0; i--) v = v * 10 + int'(x[4*i +: 4]);
    return v;
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r = '0;
    int m = v % 10000;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  // Digit-wise rule, needed only when operands hold non-decimal digits
  function automatic logic [16:0] digitwise(input logic [15:0] a, input logic [15:0] b, input logic bin);
    logic [15:0] r = '0;
    int br = int'(bin);
    int t;
    for (int i = 0; i < 4; i++) begin
      t = int'(a[4*i +: 4]) - int'(b[4*i +: 4]) - br;
      if (t < 0) begin r[4*i +: 4] = 4'((t + 10) & 15); br = 1; end
      else begin r[4*i +: 4] = 4'(t); br = 0; end
    end
    return {br[0], r};
  endfunction

  task automatic model(input logic [15:0] a, input logic [15:0] b, input logic bin,
                       output logic [15:0] d, output logic bo, output logic er,
                       output logic ng, output int lat);
    logic [16:0] tmp;
    int diff;
    er = 1'b0;
    for (int i = 0; i < 4; i++)
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) er = 1'b1;
    if (!er) begin
      diff = bcd2int(a) - bcd2int(b) - int'(bin);
      bo = (diff < 0);
      d = int2bcd(bo ? diff + 10000 : diff);
    end else begin
      tmp = digitwise(a, b, bin);
      bo = tmp[16];
      d = tmp[15:0];
    end
    ng = 1'b0;
    lat = 5;
`ifdef BCD_SIGN_MAG_EN
    if (bo) begin
      ng = 1'b1;
      lat = 9;
      if (!er) d = int2bcd(bcd2int(b) + int'(bin) - bcd2int(a));
      else begin
        tmp = digitwise(16'h0, d, 1'b0);
        d = tmp[15:0];
      end
    end
`endif
  endtask

  // Present operands before a rising edge; returns just after the accepting edge
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic bin);
    A = a; B = b; Bin = bin; Start = 1'b1;
    @(posedge Clock);
    #1;
    Start = 1'b0;
    A = 16'($urandom); B = 16'($urandom); Bin = 1'($urandom);
  endtask

  // Follows one operation from its accepting edge; returns at the negedge where Done is seen
  task automatic wait_done(input string tag, input logic [15:0] a, input logic [15:0] b, input logic bin);
    logic [15:0] ed;
    logic eb, ee, en;
    int elat, lat, busy_cnt;
    model(a, b, bin, ed, eb, ee, en, elat);
    lat = 0;
    busy_cnt = 0;
    while (lat < 40) begin
      @(negedge Clock);
      lat++;
      if (Done) break;
      if (Busy) begin
        busy_cnt++;
        if (D !== exp_prev) check({tag, "_hold"}, 32'(D), 32'(exp_prev));
        Start = 1'($urandom);
        A = 16'($urandom); B = 16'($urandom); Bin = 1'($urandom);
      end else begin
        Start = 1'b0;
      end
    end
    Start = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'(elat));
    check({tag, "_busycycles"}, 32'(busy_cnt), 32'(elat - 1));
    check({tag, "_D"}, 32'(D), 32'(ed));
    check({tag, "_Bout"}, 32'(Bout), 32'(eb));
    check({tag, "_Err"}, 32'(Err), 32'(ee));
    check({tag, "_Busy_at_done"}, 32'(Busy), 32'd0);
`ifdef BCD_SIGN_MAG_EN
    check({tag, "_Neg"}, 32'(Neg), 32'(en));
`endif
    exp_prev = ed;
  endtask

  task automatic full_op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic bin);
    @(negedge Clock);
    start_op(a, b, bin);
    wait_done(tag, a, b, bin);
    @(negedge Clock);
    check({tag, "_done_pulse"}, 32'(Done), 32'd0);
    check({tag, "_idle"}, 32'(Busy), 32'd0);
  endtask

  function automatic logic [15:0] rand_bcd(input logic allow_bad);
    logic [15:0] r;
    for (int i = 0; i < 4; i++)
      r[4*i +: 4] = (allow_bad && $urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                             : 4'($urandom_range(0, 9));
    return r;
  endfunction

  initial begin
    int done_seen;
    logic [15:0] ra, rb;
    Resetn = 1'b0; Start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    #3;
    check("rst_Busy", 32'(Busy), 32'd0);
    check("rst_Done", 32'(Done), 32'd0);
    check("rst_D", 32'(D), 32'd0);
    check("rst_Bout", 32'(Bout), 32'd0);
    check("rst_Err", 32'(Err), 32'd0);
    @(negedge Clock); @(negedge Clock);
    Resetn = 1'b1;

    full_op("t1234_0567", 16'h1234, 16'h0567, 1'b0);
    full_op("t0000_0001", 16'h0000, 16'h0001, 1'b0);
    full_op("t1000_0999b", 16'h1000, 16'h0999, 1'b1);
    full_op("t0500_0500b", 16'h0500, 16'h0500, 1'b1);
    full_op("t00A0_0001", 16'h00A0, 16'h0001, 1'b0);
    full_op("t0009_0003", 16'h0009, 16'h0003, 1'b0);
    full_op("t0000_9999b", 16'h0000, 16'h9999, 1'b1);

    // Reset two cycles into an operation aborts it without Done
    @(negedge Clock);
    start_op(16'h5555, 16'h1111, 1'b0);
    @(negedge Clock); @(negedge Clock);
    Resetn = 1'b0;
    #1;
    check("abort_Busy", 32'(Busy), 32'd0);
    check("abort_D", 32'(D), 32'd0);
    check("abort_Bout", 32'(Bout), 32'd0);
    check("abort_Err", 32'(Err), 32'd0);
    exp_prev = 16'h0;
    @(negedge Clock);
    Resetn = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clock);
      if (Done || Busy) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    full_op("after_abort", 16'h0042, 16'h0017, 1'b0);

    // Start held through DONE: second operation follows with no idle cycle
    @(negedge Clock);
    start_op(16'h9876, 16'h1234, 1'b0);
    wait_done("b2b_first", 16'h9876, 16'h1234, 1'b0);
    start_op(16'h4321, 16'h1111, 1'b0);
    wait_done("b2b_second", 16'h4321, 16'h1111, 1'b0);
    @(negedge Clock);
    check("b2b_done_pulse", 32'(Done), 32'd0);

    for (int n = 0; n < 40; n++) begin
      ra = rand_bcd(n % 5 == 4);
      rb = rand_bcd(n % 7 == 6);
      repeat ($urandom_range(0, 2)) @(negedge Clock);
      full_op("rand", ra, rb, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
